// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM state encoding,
// source-index width and the ISR vector-address function.
package irq_pkg;

  localparam int IRQ_ID_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTER  = 2'd1,
    S_IN_ISR = 2'd2,
    S_RETURN = 2'd3
  } irq_state_e;

  // ISR entry address for a source; wraps modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0]         base,
                                            input logic [31:0]         stride,
                                            input logic [IRQ_ID_W-1:0] id);
    logic [31:0] id_ext;
    id_ext = {{(32-IRQ_ID_W){1'b0}}, id};
    return base + (id_ext * stride);
  endfunction

endpackage

// File: rtl/irq_priority_arbiter.sv
// Combinational winner selection over the pending set. Lowest index wins by
// default; with IRQ_ROUND_ROBIN_EN the search starts at rr_ptr and wraps.
module irq_priority_arbiter
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]  pend,
`ifdef IRQ_ROUND_ROBIN_EN
  input  logic [IRQ_ID_W-1:0] rr_ptr,
`endif
  output logic [IRQ_ID_W-1:0] winner,
  output logic                valid
);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [2*NUM_IRQ-1:0] rot_s;
  logic [IRQ_ID_W:0]    offs_s;
  logic [IRQ_ID_W:0]    sum_s;

  assign rot_s = {pend, pend} >> rr_ptr;

  // Lowest set bit of the rotated view is the first eligible source at or after rr_ptr.
  always_comb begin
    offs_s = '0;
    valid  = 1'b0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      if (rot_s[j]) begin
        offs_s = (IRQ_ID_W+1)'(j);
        valid  = 1'b1;
      end else begin
        offs_s = offs_s;
      end
    end
    sum_s = {1'b0, rr_ptr} + offs_s;
    if (sum_s >= (IRQ_ID_W+1)'(NUM_IRQ)) begin
      sum_s = sum_s - (IRQ_ID_W+1)'(NUM_IRQ);
    end else begin
      sum_s = sum_s;
    end
    winner = sum_s[IRQ_ID_W-1:0];
  end
`else
  // Fixed priority: scan from the top so the lowest pending index is left standing.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        winner = IRQ_ID_W'(i);
        valid  = 1'b1;
      end else begin
        winner = winner;
      end
    end
  end
`endif

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/return sequencer beside the fetch stage. Optional round-robin
// arbitration is selected with the IRQ_ROUND_ROBIN_EN macro.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int          VEC_STRIDE = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_IRQ-1:0]  IRQ_REQ,
  input  logic [NUM_IRQ-1:0]  IRQ_ENABLE,
  input  logic [31:0]         CURRENT_PC,
  input  logic                INSTR_BOUNDARY,
  input  logic                MRET,
  output logic                ISR_SEL_OUT,
  output logic [31:0]         TARGET_PC,
  output logic                FLUSH,
  output logic [NUM_IRQ-1:0]  IRQ_ACK,
  output logic [IRQ_ID_W-1:0] ACTIVE_ID,
  output logic                BUSY
);

  irq_state_e            state_r, state_nxt_s;
  logic [NUM_IRQ-1:0]    pend_s;
  logic [IRQ_ID_W-1:0]   winner_s;
  logic                  valid_s;
  logic                  take_s;
  logic [31:0]           lr_r;
  logic [IRQ_ID_W-1:0]   id_r;
  logic                  sel_r, sel_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic [31:0]           target_r, target_nxt_s;
  logic [NUM_IRQ-1:0]    ack_r, ack_nxt_s;

  assign pend_s = IRQ_REQ & IRQ_ENABLE;
  assign take_s = (state_r == S_IDLE) && valid_s && INSTR_BOUNDARY;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IRQ_ID_W-1:0] rr_ptr_r;

  // Pointer moves past the source just granted so it yields next time.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_ptr_r <= '0;
    end else if (take_s) begin
      if (winner_s == IRQ_ID_W'(NUM_IRQ - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= winner_s + IRQ_ID_W'(1);
      end
    end
  end

  irq_priority_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .pend   (pend_s),
    .rr_ptr (rr_ptr_r),
    .winner (winner_s),
    .valid  (valid_s)
  );
`else
  irq_priority_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .pend   (pend_s),
    .winner (winner_s),
    .valid  (valid_s)
  );
`endif

  // Next state plus next values of the registered Moore outputs.
  always_comb begin
    state_nxt_s  = state_r;
    sel_nxt_s    = 1'b0;
    busy_nxt_s   = 1'b0;
    target_nxt_s = 32'h0000_0000;
    ack_nxt_s    = '0;
    case (state_r)
      S_IDLE: begin
        if (take_s) begin
          state_nxt_s = S_ENTER;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ENTER:  state_nxt_s = S_IN_ISR;
      S_IN_ISR: begin
        if (MRET) begin
          state_nxt_s = S_RETURN;
        end else begin
          state_nxt_s = S_IN_ISR;
        end
      end
      S_RETURN: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase

    case (state_nxt_s)
      S_ENTER: begin
        sel_nxt_s    = 1'b1;
        busy_nxt_s   = 1'b1;
        target_nxt_s = vec_addr(VEC_BASE, 32'(VEC_STRIDE), winner_s);
        ack_nxt_s    = NUM_IRQ'(1) << winner_s;
      end
      S_IN_ISR: busy_nxt_s = 1'b1;
      S_RETURN: begin
        sel_nxt_s    = 1'b1;
        busy_nxt_s   = 1'b1;
        target_nxt_s = lr_r;
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // State, link register, frozen winner and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r  <= S_IDLE;
      lr_r     <= 32'h0000_0000;
      id_r     <= '0;
      sel_r    <= 1'b0;
      busy_r   <= 1'b0;
      target_r <= 32'h0000_0000;
      ack_r    <= '0;
    end else begin
      state_r  <= state_nxt_s;
      sel_r    <= sel_nxt_s;
      busy_r   <= busy_nxt_s;
      target_r <= target_nxt_s;
      ack_r    <= ack_nxt_s;
      if (take_s) begin
        lr_r <= CURRENT_PC;
        id_r <= winner_s;
      end
    end
  end

  assign ISR_SEL_OUT = sel_r;
  assign FLUSH       = sel_r;
  assign TARGET_PC   = target_r;
  assign IRQ_ACK     = ack_r;
  assign ACTIVE_ID   = id_r;
  assign BUSY        = busy_r;

endmodule
